// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per clock; SEQ_DIVIDER_ROUND_EN adds a round-half-up stage.
// Latency: DW+1 edges from acceptance (DW+2 with rounding), 1 edge for a zero divisor.
// Backpressure: result held in DONE until out_ready; no new operands accepted until back in IDLE.
module seq_divider_u #(
    parameter int DW = 24,
    parameter int VW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic          busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

`ifdef SEQ_DIVIDER_ROUND_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DONE  = 2'd2,
        S_ROUND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] r_q, r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic          dz_q, dz_d;

    // Trial value: partial remainder shifted left with the next dividend bit.
    logic [VW:0]   trial;
    logic          trial_ge;
    assign trial    = {r_q, q_q[DW-1]};
    assign trial_ge = (trial >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = dividend[VW-1:0];
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = CW'(DW - 1);
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Remainder stays below the divisor, so the difference fits in VW bits.
                r_d = trial_ge ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
                q_d = {q_q[DW-2:0], trial_ge};
                if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef SEQ_DIVIDER_ROUND_EN
            S_ROUND: begin
                if (({r_q, 1'b0} >= {1'b0, dvs_q}) && !(&q_q)) begin
                    q_d = q_q + 1'b1;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign quotient  = q_q;
    assign remainder = r_q;
    assign div_zero  = dz_q;

endmodule
